i2s_tdm_clock_gen: RTL and testbench

Runtime-configurable bit-clock and word-select generator for I2S, left-justified and TDM/DSP serial audio links. It replaces the fixed-parameter I2S clock generator with a programmable SCK divider, slot width, slot count and framing mode. It adds gapless start/stop control and per-bit/slot position outputs. It sits beside the audio serializers and deserializers, which consume the edge strobes and the slot and bit indices.

---
 rtl/i2s_tdm_clock_gen_pkg.sv | 17 +
 rtl/i2s_tdm_clock_gen_if.sv | 33 +++
 rtl/i2s_tdm_clock_gen_clk_div_phase.sv | 60 ++++++
 rtl/i2s_tdm_clock_gen.sv | 194 +++++++++++++++++++
 tb/tb_i2s_tdm_clock_gen.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_tdm_clock_gen_pkg.sv
// Shared audio-clocking types: serial framing modes and the generator FSM states.
package i2s_tdm_clock_gen_pkg;

    typedef enum logic [1:0] {
        MODE_I2S  = 2'b00,
        MODE_LJ   = 2'b01,
        MODE_DSP  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } state_e;

endpackage

// File: rtl/i2s_tdm_clock_gen_if.sv
// Configuration inputs and clock/position outputs of the serial audio clock generator.
interface i2s_tdm_clock_gen_if #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned SLOT_BITS_W = 6,
    parameter int unsigned SLOTS_W     = 4
) ();
    logic                   en_i;
    logic [DIV_W-1:0]       div_i;
    logic [SLOT_BITS_W-1:0] slot_bits_i;
    logic [SLOTS_W-1:0]     num_slots_i;
    logic [1:0]             mode_i;
    logic                   sck_o;
    logic                   ws_o;
    logic                   sck_rise_o;
    logic                   sck_fall_o;
    logic                   frame_start_o;
    logic [SLOTS_W-1:0]     slot_idx_o;
    logic [SLOT_BITS_W-1:0] bit_idx_o;
    logic                   busy_o;
    logic                   cfg_err_o;

    modport slave (
        input  en_i, div_i, slot_bits_i, num_slots_i, mode_i,
        output sck_o, ws_o, sck_rise_o, sck_fall_o, frame_start_o,
               slot_idx_o, bit_idx_o, busy_o, cfg_err_o
    );

    modport master (
        output en_i, div_i, slot_bits_i, num_slots_i, mode_i,
        input  sck_o, ws_o, sck_rise_o, sck_fall_o, frame_start_o,
               slot_idx_o, bit_idx_o, busy_o, cfg_err_o
    );
endinterface

// File: rtl/i2s_tdm_clock_gen_clk_div_phase.sv
// Two-phase programmable divider: low phase first (div - div/2 cycles), then div/2 high cycles.
module clk_div_phase #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_sck,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_period_end
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_m1;
    logic [DIV_W-1:0] w_low;
    logic             w_wrap;
    logic             r_sck;
    logic             r_rise;
    logic             r_fall;

    // Phase counter next value and low-phase length
    always_comb begin
        w_div_m1 = i_div - DIV_W'(1);
        w_low    = i_div - (i_div >> 1);
        w_wrap   = (r_cnt == w_div_m1);
        if (w_wrap) begin
            w_cnt_nxt = DIV_W'(0);
        end else begin
            w_cnt_nxt = r_cnt + DIV_W'(1);
        end
    end

    // Count register with sck level and edge strobes registered together
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt  <= DIV_W'(0);
            r_sck  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (i_en) begin
            r_cnt  <= w_cnt_nxt;
            r_sck  <= (w_cnt_nxt >= w_low);
            r_rise <= (w_cnt_nxt == w_low);
            r_fall <= (w_cnt_nxt == DIV_W'(0));
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end
    end

    assign o_sck        = r_sck;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;
    assign o_period_end = i_en && w_wrap;

endmodule

// File: rtl/i2s_tdm_clock_gen.sv
// Runtime-configurable SCK/WS generator for I2S, left-justified and DSP/TDM links with gapless stop.
module i2s_tdm_clock_gen
    import i2s_tdm_clock_gen_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned SLOT_BITS_W = 6,
    parameter int unsigned SLOTS_W     = 4,
    parameter logic        WS_POL      = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    i2s_tdm_clock_gen_if.slave  bus_if
);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [DIV_W-1:0]       r_div;
    logic [SLOT_BITS_W-1:0] r_sb_m1;
    logic [SLOTS_W-1:0]     r_ns;
    mode_e                  r_mode;
    logic                   w_latch;
    logic [SLOTS_W-1:0]     r_slot;
    logic [SLOTS_W-1:0]     w_slot_nxt;
    logic [SLOTS_W-1:0]     w_slot_adv;
    logic [SLOT_BITS_W-1:0] r_bit;
    logic [SLOT_BITS_W-1:0] w_bit_nxt;
    logic [SLOT_BITS_W-1:0] w_bit_adv;
    logic [SLOT_BITS_W-1:0] w_sb_in_m1;
    logic                   r_ws;
    logic                   w_ws_nxt;
    logic                   r_fs;
    logic                   w_fs_nxt;
    logic                   r_busy;
    logic                   r_err;
    logic                   w_err_nxt;
    logic                   w_wrap;
    logic                   w_sck;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_period_end;

    function automatic logic cfg_ok(input logic [DIV_W-1:0]       d,
                                    input logic [SLOT_BITS_W-1:0] sb,
                                    input logic [SLOTS_W-1:0]     ns,
                                    input logic [1:0]             md);
        logic pair_mode;
        pair_mode = (mode_e'(md) == MODE_I2S) || (mode_e'(md) == MODE_LJ);
        return (d >= DIV_W'(2)) && (sb >= SLOT_BITS_W'(2)) && (ns != SLOTS_W'(0)) &&
               (mode_e'(md) != MODE_RSVD) && !(pair_mode && ns[0]);
    endfunction

    // I2S looks one bit ahead: on bit 0 of a slot it already shows the next slot's level.
    function automatic logic ws_level(input mode_e                  md,
                                      input logic [SLOTS_W-1:0]     slot,
                                      input logic [SLOT_BITS_W-1:0] bit_i,
                                      input logic [SLOT_BITS_W-1:0] sb_m1,
                                      input logic [SLOTS_W-1:0]     ns);
        logic [SLOTS_W-1:0] half;
        logic [SLOTS_W-1:0] eff;
        logic               lvl;
        half = ns >> 1;
        if ((md == MODE_I2S) && (bit_i == SLOT_BITS_W'(0))) begin
            eff = (slot == ns - SLOTS_W'(1)) ? SLOTS_W'(0) : slot + SLOTS_W'(1);
        end else begin
            eff = slot;
        end
        case (md)
            MODE_DSP: lvl = ((slot == SLOTS_W'(0)) && (bit_i == sb_m1)) ? ~WS_POL : WS_POL;
            default:  lvl = (eff < half) ? WS_POL : ~WS_POL;
        endcase
        return lvl;
    endfunction

    clk_div_phase #(
        .DIV_W (DIV_W)
    ) u_div (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_clr        (r_state == ST_IDLE),
        .i_en         (r_state != ST_IDLE),
        .i_div        (r_div),
        .o_sck        (w_sck),
        .o_rise       (w_rise),
        .o_fall       (w_fall),
        .o_period_end (w_period_end)
    );

    // Next state, next position and next word-select level
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_bit_nxt   = r_bit;
        w_ws_nxt    = r_ws;
        w_fs_nxt    = 1'b0;
        w_err_nxt   = r_err;
        w_latch     = 1'b0;
        w_sb_in_m1  = bus_if.slot_bits_i - SLOT_BITS_W'(1);
        w_wrap      = (r_slot == r_ns - SLOTS_W'(1)) && (r_bit == SLOT_BITS_W'(0));
        if (r_bit == SLOT_BITS_W'(0)) begin
            w_bit_adv  = r_sb_m1;
            w_slot_adv = (r_slot == r_ns - SLOTS_W'(1)) ? SLOTS_W'(0) : r_slot + SLOTS_W'(1);
        end else begin
            w_bit_adv  = r_bit - SLOT_BITS_W'(1);
            w_slot_adv = r_slot;
        end
        case (r_state)
            ST_IDLE: begin
                if (bus_if.en_i) begin
                    if (cfg_ok(bus_if.div_i, bus_if.slot_bits_i, bus_if.num_slots_i, bus_if.mode_i)) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_RUN;
                        w_slot_nxt  = SLOTS_W'(0);
                        w_bit_nxt   = w_sb_in_m1;
                        w_ws_nxt    = ws_level(mode_e'(bus_if.mode_i), SLOTS_W'(0), w_sb_in_m1,
                                               w_sb_in_m1, bus_if.num_slots_i);
                        w_fs_nxt    = 1'b1;
                        w_err_nxt   = 1'b0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN, ST_STOP: begin
                w_state_nxt = bus_if.en_i ? ST_RUN : ST_STOP;
                // A pending stop only takes effect where the next frame would begin.
                if (w_period_end) begin
                    if (w_wrap && (r_state == ST_STOP) && !bus_if.en_i) begin
                        w_state_nxt = ST_IDLE;
                        w_slot_nxt  = SLOTS_W'(0);
                        w_bit_nxt   = SLOT_BITS_W'(0);
                        w_ws_nxt    = WS_POL;
                    end else begin
                        w_slot_nxt = w_slot_adv;
                        w_bit_nxt  = w_bit_adv;
                        w_ws_nxt   = ws_level(r_mode, w_slot_adv, w_bit_adv, r_sb_m1, r_ns);
                        w_fs_nxt   = w_wrap;
                    end
                end else begin
                    w_fs_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shadow configuration captured only on an accepted start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div   <= DIV_W'(0);
            r_sb_m1 <= SLOT_BITS_W'(0);
            r_ns    <= SLOTS_W'(0);
            r_mode  <= MODE_I2S;
        end else if (w_latch) begin
            r_div   <= bus_if.div_i;
            r_sb_m1 <= w_sb_in_m1;
            r_ns    <= bus_if.num_slots_i;
            r_mode  <= mode_e'(bus_if.mode_i);
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_slot  <= SLOTS_W'(0);
            r_bit   <= SLOT_BITS_W'(0);
            r_ws    <= WS_POL;
            r_fs    <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_bit   <= w_bit_nxt;
            r_ws    <= w_ws_nxt;
            r_fs    <= w_fs_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_err   <= w_err_nxt;
        end
    end

    assign bus_if.sck_o         = w_sck;
    assign bus_if.sck_rise_o    = w_rise;
    assign bus_if.sck_fall_o    = w_fall;
    assign bus_if.ws_o          = r_ws;
    assign bus_if.frame_start_o = r_fs;
    assign bus_if.slot_idx_o    = r_slot;
    assign bus_if.bit_idx_o     = r_bit;
    assign bus_if.busy_o        = r_busy;
    assign bus_if.cfg_err_o     = r_err;

endmodule

// File: tb/tb_i2s_tdm_clock_gen.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle expectations, a negedge monitor checks them.
module tb_i2s_tdm_clock_gen;

    localparam int K_SCK  = 0;
    localparam int K_WS   = 1;
    localparam int K_RISE = 2;
    localparam int K_FALL = 3;
    localparam int K_FS   = 4;
    localparam int K_SLOT = 5;
    localparam int K_BIT  = 6;
    localparam int K_BUSY = 7;
    localparam int K_ERR  = 8;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    bit   drain = 1'b0;
    bit   drained = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_tdm_clock_gen_if bus_if ();

    i2s_tdm_clock_gen dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus_if)
    );

    function automatic int actual(input int sig);
        case (sig)
            K_SCK:   return int'(bus_if.sck_o);
            K_WS:    return int'(bus_if.ws_o);
            K_RISE:  return int'(bus_if.sck_rise_o);
            K_FALL:  return int'(bus_if.sck_fall_o);
            K_FS:    return int'(bus_if.frame_start_o);
            K_SLOT:  return int'(bus_if.slot_idx_o);
            K_BIT:   return int'(bus_if.bit_idx_o);
            K_BUSY:  return int'(bus_if.busy_o);
            default: return int'(bus_if.cfg_err_o);
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            K_SCK:   return "sck";
            K_WS:    return "ws";
            K_RISE:  return "sck_rise";
            K_FALL:  return "sck_fall";
            K_FS:    return "frame_start";
            K_SLOT:  return "slot_idx";
            K_BIT:   return "bit_idx";
            K_BUSY:  return "busy";
            default: return "cfg_err";
        endcase
    endfunction

    // Monitor: compare every expectation that falls due on this cycle
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                checks++;
                if (actual(q[i].sig) != q[i].val) begin
                    fails++;
                    $display("FAIL %s at cycle %0d: got %0d expected %0d",
                             sig_name(q[i].sig), cyc, actual(q[i].sig), q[i].val);
                end
                q.delete(i);
            end
        end
        if (drain && !drained) begin
            foreach (q[i]) begin
                checks++;
                fails++;
                $display("FAIL %s at cycle %0d: never sampled", sig_name(q[i].sig), q[i].cyc);
            end
            drained = 1'b1;
        end
    end

    task automatic ex(input int c, input int sig, input int v);
        q.push_back('{c, sig, v});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input int d, input int sb, input int ns, input int md, output int s);
        bus_if.div_i       = 8'(d);
        bus_if.slot_bits_i = 6'(sb);
        bus_if.num_slots_i = 4'(ns);
        bus_if.mode_i      = 2'(md);
        bus_if.en_i        = 1'b1;
        s = cyc + 1;
    endtask

    // Rejected start, then a short valid I2S frame (div=2, 2x2 bits) that clears the error.
    task automatic bad_then_good(input int d, input int sb, input int ns, input int md);
        int c;
        c = cyc;
        bus_if.div_i       = 8'(d);
        bus_if.slot_bits_i = 6'(sb);
        bus_if.num_slots_i = 4'(ns);
        bus_if.mode_i      = 2'(md);
        bus_if.en_i        = 1'b1;
        ex(c + 1, K_ERR, 1); ex(c + 1, K_BUSY, 0); ex(c + 1, K_SCK, 0);
        @(posedge clk); #1;
        bus_if.div_i       = 8'd2;
        bus_if.slot_bits_i = 6'd2;
        bus_if.num_slots_i = 4'd2;
        bus_if.mode_i      = 2'b00;
        ex(c + 2, K_ERR, 0); ex(c + 2, K_BUSY, 1); ex(c + 2, K_FS, 1);
        @(posedge clk); #1;
        bus_if.en_i = 1'b0;
        ex(c + 9, K_BUSY, 1); ex(c + 10, K_BUSY, 0); ex(c + 10, K_ERR, 0);
        wait_until(c + 12);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst                = 1'b1;
        bus_if.en_i        = 1'b0;
        bus_if.div_i       = 8'd0;
        bus_if.slot_bits_i = 6'd0;
        bus_if.num_slots_i = 4'd0;
        bus_if.mode_i      = 2'b00;
        ex(2, K_SCK, 0); ex(2, K_WS, 0); ex(2, K_BUSY, 0); ex(2, K_ERR, 0);
        ex(2, K_SLOT, 0); ex(2, K_BIT, 0); ex(2, K_FS, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic I2S: div 8, 16-bit slots, stereo; frame = 256 cycles
        wait_until(10);
        start(8, 16, 2, 0, s);
        ex(s, K_FS, 1); ex(s, K_SCK, 0); ex(s, K_BIT, 15); ex(s, K_SLOT, 0);
        ex(s, K_WS, 0); ex(s, K_BUSY, 1); ex(s, K_ERR, 0);
        ex(s + 3, K_SCK, 0); ex(s + 4, K_SCK, 1); ex(s + 4, K_RISE, 1); ex(s + 5, K_RISE, 0);
        ex(s + 8, K_SCK, 0); ex(s + 8, K_FALL, 1); ex(s + 8, K_BIT, 14);
        ex(s + 119, K_WS, 0); ex(s + 120, K_WS, 1); ex(s + 120, K_BIT, 0);
        ex(s + 128, K_SLOT, 1); ex(s + 128, K_BIT, 15);
        ex(s + 247, K_WS, 1); ex(s + 248, K_WS, 0);
        ex(s + 255, K_FS, 0); ex(s + 256, K_FS, 1); ex(s + 256, K_SLOT, 0); ex(s + 512, K_FS, 1);
        ex(s + 700, K_WS, 1); ex(s + 700, K_BUSY, 1); ex(s + 767, K_SCK, 1); ex(s + 767, K_BUSY, 1);
        ex(s + 768, K_BUSY, 0); ex(s + 768, K_SCK, 0); ex(s + 768, K_WS, 0); ex(s + 768, K_FS, 0);
        ex(s + 768, K_SLOT, 0); ex(s + 768, K_BIT, 0); ex(s + 772, K_SCK, 0);
        wait_until(s + 512 + 150);
        bus_if.en_i = 1'b0;

        // Re-assert during STOP: frame continues, next frame starts on time
        wait_until(s + 780);
        start(8, 16, 2, 0, s);
        ex(s + 101, K_FS, 0); ex(s + 102, K_BUSY, 1); ex(s + 128, K_SLOT, 1);
        ex(s + 256, K_FS, 1); ex(s + 256, K_BUSY, 1); ex(s + 260, K_SCK, 1); ex(s + 260, K_RISE, 1);
        ex(s + 511, K_BUSY, 1); ex(s + 512, K_BUSY, 0);
        wait_until(s + 50);  bus_if.en_i = 1'b0;
        wait_until(s + 100); bus_if.en_i = 1'b1;
        wait_until(s + 300); bus_if.en_i = 1'b0;

        // Odd divider, left-justified: low 3, high 2; frame = 20 cycles
        wait_until(s + 520);
        start(5, 2, 2, 1, s);
        ex(s, K_SCK, 0); ex(s + 2, K_SCK, 0); ex(s + 2, K_RISE, 0); ex(s + 3, K_SCK, 1);
        ex(s + 3, K_RISE, 1); ex(s + 4, K_SCK, 1); ex(s + 5, K_SCK, 0); ex(s + 5, K_FALL, 1);
        ex(s + 5, K_BIT, 0); ex(s + 5, K_WS, 0); ex(s + 9, K_WS, 0); ex(s + 10, K_WS, 1);
        ex(s + 10, K_SLOT, 1); ex(s + 10, K_BIT, 1); ex(s + 20, K_FS, 1); ex(s + 20, K_WS, 0);
        ex(s + 39, K_BUSY, 1); ex(s + 40, K_BUSY, 0);
        wait_until(s + 25);
        bus_if.en_i = 1'b0;

        // TDM8 DSP: div 4, 32-bit slots; frame = 1024 cycles; div change while running is ignored
        wait_until(s + 45);
        start(4, 32, 8, 2, s);
        ex(s, K_WS, 1); ex(s, K_FS, 1); ex(s + 3, K_WS, 1); ex(s + 4, K_WS, 0); ex(s + 4, K_BIT, 30);
        ex(s + 128, K_SLOT, 1); ex(s + 128, K_WS, 0); ex(s + 896, K_SLOT, 7);
        ex(s + 1023, K_BIT, 0); ex(s + 1023, K_SLOT, 7); ex(s + 1023, K_WS, 0);
        ex(s + 1024, K_FS, 1); ex(s + 1024, K_WS, 1); ex(s + 1024, K_SLOT, 0);
        ex(s + 1026, K_RISE, 1); ex(s + 1028, K_WS, 0); ex(s + 1028, K_FALL, 1);
        ex(s + 2047, K_BUSY, 1); ex(s + 2048, K_BUSY, 0); ex(s + 2048, K_WS, 0);
        wait_until(s + 10);
        bus_if.div_i = 8'd10;
        wait_until(s + 1030);
        bus_if.en_i = 1'b0;

        // Rejected configurations: div=1, odd slot count in I2S, reserved mode
        wait_until(s + 2055);
        bad_then_good(1, 16, 2, 0);
        bad_then_good(8, 16, 3, 0);
        bad_then_good(8, 16, 2, 3);

        // Mid-frame reset during slot 1, then a fresh start
        start(8, 16, 2, 0, s);
        ex(s + 150, K_SLOT, 1); ex(s + 150, K_WS, 1); ex(s + 150, K_BUSY, 1);
        ex(s + 151, K_SCK, 0); ex(s + 151, K_WS, 0); ex(s + 151, K_SLOT, 0); ex(s + 151, K_BIT, 0);
        ex(s + 151, K_BUSY, 0); ex(s + 151, K_FS, 0);
        ex(s + 152, K_FS, 1); ex(s + 152, K_BIT, 15); ex(s + 152, K_BUSY, 1);
        ex(s + 407, K_BUSY, 1); ex(s + 408, K_BUSY, 0);
        wait_until(s + 150);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_until(s + 160);
        bus_if.en_i = 1'b0;

        wait_until(s + 415);
        drain = 1'b1;
        for (int k = 0; k < 4 && !drained; k++) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
